// File: rtl/tanh_maxpool_2x2.sv
// ---------------------------------------------------------------------------
// tanh_maxpool_2x2
//
// Purpose:
//   2x2 stride-2 max pooling over a raster-order stream of IEEE-754 single
//   precision activation values coming out of the tanh unit. A half-row line
//   buffer keeps the horizontal pair maxima of each even row until the matching
//   odd row arrives, at which point one pooled value per window is emitted.
//
// Parameters:
//   IN_WIDTH   feature-map columns (even, >= 2)
//   IN_HEIGHT  feature-map rows    (even, >= 2)
//
// Ports:
//   clk         in   1   clock, all state on rising edge
//   reset       in   1   asynchronous active-low reset
//   in_valid    in   1   strobe: in_data holds the next activation value
//   in_data     in   32  IEEE-754 activation value
//   out_valid   out  1   strobe: out_data holds a pooled result
//   out_data    out  32  max of the current 2x2 window (held when idle)
//   frame_done  out  1   strobe coincident with the last out_valid of a frame
//   nan_seen    out  1   sticky NaN indicator (only with MAXPOOL_NAN_FLAG_EN)
//
// Optional feature macro: MAXPOOL_NAN_FLAG_EN
//   Defined   -> adds nan_seen, set sticky on any accepted NaN input.
//   Undefined -> no port, no detection logic.
// ---------------------------------------------------------------------------
module tanh_maxpool_2x2 #(
  parameter int IN_WIDTH  = 28,
  parameter int IN_HEIGHT = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        frame_done
`ifdef MAXPOOL_NAN_FLAG_EN
  ,
  output logic        nan_seen
`endif
);

  localparam int CW = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 1;
  localparam int RW = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
  localparam int BD = IN_WIDTH / 2;
  localparam int BW = (BD > 1) ? $clog2(BD) : 1;

  // Sign-magnitude maximum. Operand a is always the earlier-arrived value, so
  // every tie (identical patterns, or +0 against -0) resolves to a.
  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = a;
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
      r = a;
    end else if (a[31] != b[31]) begin
      r = a[31] ? b : a;
    end else if (a[31] == 1'b0) begin
      r = (b[30:0] > a[30:0]) ? b : a;
    end else begin
      r = (b[30:0] < a[30:0]) ? b : a;
    end
    return r;
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [31:0]   pair_q, pair_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          frame_done_q, frame_done_d;
  logic [31:0]   line_q [BD];

  logic          last_col_s;
  logic          last_row_s;
  logic          line_we_s;
  logic [BW-1:0] line_idx_s;
  logic [31:0]   pm_s;

  // Next-state logic: raster counters, pair register, line buffer write and
  // pooled-output generation for every accepted value.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    line_we_s    = 1'b0;
    last_col_s   = (col_q == CW'(IN_WIDTH - 1));
    last_row_s   = (row_q == RW'(IN_HEIGHT - 1));
    line_idx_s   = BW'(col_q >> 1);
    pm_s         = fmax(pair_q, in_data);

    if (in_valid) begin
      if (col_q[0] == 1'b0) begin
        pair_d = in_data;
      end else if (row_q[0] == 1'b0) begin
        line_we_s = 1'b1;
      end else begin
        // The line-buffer entry arrived a row earlier, so it is operand a.
        out_valid_d  = 1'b1;
        out_data_d   = fmax(line_q[line_idx_s], pm_s);
        frame_done_d = last_row_s & last_col_s;
      end

      if (last_col_s) begin
        col_d = {CW{1'b0}};
        if (last_row_s) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
    end
  end

  // Control, pair and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      pair_q       <= 32'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'd0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer storage; contents are don't-care after reset, so no reset.
  always_ff @(posedge clk) begin
    if (line_we_s) begin
      line_q[line_idx_s] <= pm_s;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

`ifdef MAXPOOL_NAN_FLAG_EN
  logic nan_q, nan_d;
  logic is_nan_s;

  // NaN = all-ones exponent with a non-zero mantissa; flag is sticky.
  always_comb begin
    is_nan_s = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    if (in_valid && is_nan_s) begin
      nan_d = 1'b1;
    end else begin
      nan_d = nan_q;
    end
  end

  // Sticky NaN register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nan_q <= 1'b0;
    end else begin
      nan_q <= nan_d;
    end
  end

  assign nan_seen = nan_q;
`endif

endmodule

// File: tb/tb_tanh_maxpool_2x2.sv
// ---------------------------------------------------------------------------
// tb_tanh_maxpool_2x2
//
// Drives a 2x2 and a 4x4 instance of tanh_maxpool_2x2 with directed and
// randomized streams. A reference model stores each frame as a 2-D array and
// computes every window maximum from a signed magnitude key, keeping the first
// maximal value in arrival order. Outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_tanh_maxpool_2x2;

  logic        clk = 1'b0;
  logic        reset;
  logic        v22, v44;
  logic [31:0] din;
  logic        ov22, fd22, ov44, fd44;
  logic [31:0] od22, od44;
`ifdef MAXPOOL_NAN_FLAG_EN
  logic        ns22, ns44;
`endif

  always #5 clk = ~clk;

  tanh_maxpool_2x2 #(.IN_WIDTH(2), .IN_HEIGHT(2)) u_dut22 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (v22),
    .in_data    (din),
    .out_valid  (ov22),
    .out_data   (od22),
    .frame_done (fd22)
`ifdef MAXPOOL_NAN_FLAG_EN
    ,
    .nan_seen   (ns22)
`endif
  );

  tanh_maxpool_2x2 #(.IN_WIDTH(4), .IN_HEIGHT(4)) u_dut44 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (v44),
    .in_data    (din),
    .out_valid  (ov44),
    .out_data   (od44),
    .frame_done (fd44)
`ifdef MAXPOOL_NAN_FLAG_EN
    ,
    .nan_seen   (ns44)
`endif
  );

  int errors = 0;
  int checks = 0;
  int p44    = 0;
  int f44    = 0;

  int          gw [2] = '{2, 4};
  int          gh [2] = '{2, 4};
  logic [31:0] pix [2][4][4];
  int          mcol [2];
  int          mrow [2];
  logic        exp_v [2];
  logic        exp_fd [2];
  logic        exp_nan [2];
  logic [31:0] exp_d [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  // Ordering key: positive values by magnitude, negative values by minus
  // magnitude, so +0 and -0 share key 0.
  function automatic longint key(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcol[d]    = 0;
      mrow[d]    = 0;
      exp_v[d]   = 1'b0;
      exp_fd[d]  = 1'b0;
      exp_d[d]   = 32'd0;
      exp_nan[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input logic v, input logic [31:0] x);
    int          r;
    int          c;
    logic [31:0] win [4];
    logic [31:0] best;
    exp_v[d]  = 1'b0;
    exp_fd[d] = 1'b0;
    if (v) begin
      r = mrow[d];
      c = mcol[d];
      pix[d][r][c] = x;
      if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) exp_nan[d] = 1'b1;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        win = '{pix[d][r-1][c-1], pix[d][r-1][c], pix[d][r][c-1], pix[d][r][c]};
        best = win[0];
        for (int i = 1; i < 4; i++) begin
          if (key(win[i]) > key(best)) best = win[i];
        end
        exp_v[d]  = 1'b1;
        exp_d[d]  = best;
        exp_fd[d] = (r == gh[d] - 1) && (c == gw[d] - 1);
      end
      c++;
      if (c == gw[d]) begin
        c = 0;
        r++;
        if (r == gh[d]) r = 0;
      end
      mrow[d] = r;
      mcol[d] = c;
    end
  endtask

  task automatic check_outputs();
    check_val("out_valid22",  {31'd0, ov22}, {31'd0, exp_v[0]});
    check_val("out_data22",   od22,          exp_d[0]);
    check_val("frame_done22", {31'd0, fd22}, {31'd0, exp_fd[0]});
    check_val("out_valid44",  {31'd0, ov44}, {31'd0, exp_v[1]});
    check_val("out_data44",   od44,          exp_d[1]);
    check_val("frame_done44", {31'd0, fd44}, {31'd0, exp_fd[1]});
`ifdef MAXPOOL_NAN_FLAG_EN
    check_val("nan_seen22",   {31'd0, ns22}, {31'd0, exp_nan[0]});
    check_val("nan_seen44",   {31'd0, ns44}, {31'd0, exp_nan[1]});
`endif
    if (ov44 === 1'b1) p44++;
    if (fd44 === 1'b1) f44++;
  endtask

  // One clock: check what the previous edge produced, then drive new inputs.
  task automatic cycle(input logic a, input logic b, input logic [31:0] x);
    @(negedge clk);
    check_outputs();
    model_step(0, a, x);
    model_step(1, b, x);
    v22 = a;
    v44 = b;
    din = x;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    v22   = 1'b0;
    v44   = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0:       r = 32'h0000_0000;
      1:       r = 32'h8000_0000;
      2:       r = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'($urandom_range(0, 3))};
      3:       r = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'h3F80_0000};
      default: r = 32'($urandom);
    endcase
    return r;
  endfunction

  logic [31:0] t1 [4] = '{32'h3E80_0000, 32'h3F00_0000, 32'hBF00_0000, 32'h3F09_6F7B};
  logic [31:0] t2 [4] = '{32'hBF00_0000, 32'hBE80_0000, 32'hBF80_0000, 32'hBF40_0000};
  logic [31:0] t4 [4] = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000};

  initial begin
    reset = 1'b0;
    v22   = 1'b0;
    v44   = 1'b0;
    din   = 32'd0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Directed 2x2 windows: general max, all-negative, signed-zero tie.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, t1[i]);
    cycle(1'b0, 1'b0, 32'($urandom));
    check_val("t1_data", od22, 32'h3F09_6F7B);
    check_val("t1_fd", {31'd0, fd22}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, t2[i]);
    cycle(1'b0, 1'b0, 32'($urandom));
    check_val("t2_data", od22, 32'hBE80_0000);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, t4[i]);
    cycle(1'b0, 1'b0, 32'($urandom));
    check_val("t4_data", od22, 32'h8000_0000);

    // 4x4 frame with idle gaps and one raised pixel, then a back-to-back frame.
    p44 = 0;
    f44 = 0;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 32'($urandom));
      cycle(1'b0, 1'b1, (i == 7) ? 32'h3F80_0001 : 32'h3F80_0000);
    end
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 32'h3F80_0000);
    cycle(1'b0, 1'b0, 32'($urandom));
    check_val("t3_pulses", 32'(p44), 32'd8);
    check_val("t3_frames", 32'(f44), 32'd2);

    // Reset while the first window result is on the outputs.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, rand_val());
    cycle(1'b0, 1'b0, 32'($urandom));
    check_val("t5_pre_valid", {31'd0, ov44}, 32'd1);
    do_reset();
    check_val("t5_post_valid", {31'd0, ov44}, 32'd0);
    p44 = 0;
    f44 = 0;
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, rand_val());
    cycle(1'b0, 1'b0, 32'($urandom));
    check_val("t5_pulses", 32'(p44), 32'd4);
    check_val("t5_frames", 32'(f44), 32'd1);

`ifdef MAXPOOL_NAN_FLAG_EN
    // Infinity leaves the flag clear; a quiet NaN at pixel 2 sets it.
    do_reset();
    cycle(1'b0, 1'b1, 32'h7F80_0000);
    cycle(1'b0, 1'b1, 32'h7F80_0000);
    cycle(1'b0, 1'b0, 32'($urandom));
    check_val("t6_inf", {31'd0, ns44}, 32'd0);
    cycle(1'b0, 1'b1, 32'h7FC0_0000);
    cycle(1'b0, 1'b0, 32'($urandom));
    check_val("t6_nan", {31'd0, ns44}, 32'd1);
`endif

    // Randomized traffic on both instances with random gaps.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_val());
    end
    repeat (3) cycle(1'b0, 1'b0, 32'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tanh_maxpool_2x2.md
Name: tanh_maxpool_2x2

Overview:
Downstream stage of the 32-bit IEEE-754 tanh activation unit. Consumes the stream of activated feature-map values in raster order, one value per in_valid strobe, and performs 2x2 stride-2 max pooling. Emits one pooled single-precision value per 2x2 window to the next layer. A half-row line buffer holds partial maxima between even and odd rows.

Parameters:
IN_WIDTH, 28, feature-map columns; must be even and >= 2
IN_HEIGHT, 28, feature-map rows; must be even and >= 2

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  one-cycle strobe: in_data holds the next tanh result
in_data  input  32  IEEE-754 single-precision activation value
out_valid  output  1  one-cycle strobe: out_data holds a pooled result
out_data  output  32  IEEE-754 max of the current 2x2 window
frame_done  output  1  one-cycle strobe, coincident with the last out_valid of a frame

Behaviour:
- Reset (reset=0, async): out_valid=0, out_data=0, frame_done=0, col=0, row=0, pair register cleared. Line buffer contents are don't-care. Takes effect immediately, including mid-frame. The next frame starts at pixel (0,0) after reset releases.
- No backpressure. in_valid may have arbitrary gaps. Cycles with in_valid=0 change no state.
- Counters col (0..IN_WIDTH-1) and row (0..IN_HEIGHT-1) advance on each accepted value.
  - col wraps to 0 at IN_WIDTH-1 and increments row.
  - row wraps to 0 after the last pixel. The next frame follows back-to-back with no idle cycle required.
- Even col: in_data is stored in the pair register.
- Odd col: pm = fmax(pair register, in_data).
  - Even row: buf[col/2] <= pm.
  - Odd row: result = fmax(buf[col/2], pm). Registered to out_data with out_valid=1 on the next clock edge (latency 1 cycle after the accepted value).
- frame_done=1 in the same cycle as out_valid for the window at row IN_HEIGHT-1, col IN_WIDTH-1.
- out_data holds its last value when out_valid=0.
- Output count per frame: (IN_WIDTH/2)*(IN_HEIGHT/2).
- fmax(a,b) uses sign-magnitude ordering:
  - both sign bits 0: larger bits[30:0] wins
  - both sign bits 1: smaller bits[30:0] wins
  - signs differ: the sign-0 operand wins
  - ties (equal patterns, or +0 vs -0) return the earlier-arrived operand, bit-exact
  - no NaN/Inf special-casing; those patterns are ordered by the same rule
- Line buffer: IN_WIDTH/2 entries x 32 bits. Written only on even rows, read only on odd rows. Never read and written to the same entry in one cycle.

Optional Feature:
MAXPOOL_NAN_FLAG_EN
- Defined: adds output port nan_seen (1 bit).
  - Reset value 0.
  - Set sticky on the clock edge after any accepted in_data with bits[30:23]=8'hFF and bits[22:0]!=0.
  - Cleared only by reset.
  - Pooling data path is unchanged.
- Undefined: port absent, no detection logic.

Test Plan:
1. IN_WIDTH=2, IN_HEIGHT=2; feed 3E800000, 3F000000, BF000000, 3F096F7B -> one out_valid with out_data=3F096F7B and frame_done=1 in the same cycle, 1 cycle after the 4th strobe.
2. Same geometry; feed BF000000, BE800000, BF800000, BF400000 -> out_data=BE800000 (-0.25).
3. IN_WIDTH=4, IN_HEIGHT=4; feed 16 values 3F800000 with a single 3F800001 at (1,3) and gaps of 0-3 idle cycles -> four out_valid pulses. The second pulse is 3F800001, the others are 3F800000. frame_done is on the fourth pulse only. A second back-to-back frame yields four more pulses.
4. Tie: feed 80000000, 00000000, 80000000, 80000000 -> out_data=80000000 (earliest operand kept).
5. Reset mid-frame: assert reset=0 after 6 values of a 4x4 frame -> out_valid/frame_done drop to 0 immediately. A fresh 16-value frame after release gives exactly 4 correct outputs.
6. With MAXPOOL_NAN_FLAG_EN: feed 7FC00000 at pixel 2 -> nan_seen=1 from the next edge onward until reset. 7F800000 (Inf) alone leaves nan_seen=0.
